// File: rtl/simon_pkg.sv
// Shared Simon key-schedule constants, configuration lookups and the FSM state type.
package simon_pkg;

  // Published z sequences; the leftmost character (bit 61) is z[0].
  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
  localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } ks_state_t;

  // Returns 0 for an unsupported pair so the top can refuse to elaborate.
  function automatic int rounds_of(input int word, input int key_words);
    int r;
    r = 0;
    if (word == 16 && key_words == 4) r = 32;
    else if (word == 24 && key_words == 3) r = 36;
    else if (word == 24 && key_words == 4) r = 36;
    else if (word == 32 && key_words == 3) r = 42;
    else if (word == 32 && key_words == 4) r = 44;
    else if (word == 48 && key_words == 2) r = 52;
    else if (word == 48 && key_words == 3) r = 54;
    else if (word == 64 && key_words == 2) r = 68;
    else if (word == 64 && key_words == 3) r = 69;
    else if (word == 64 && key_words == 4) r = 72;
    return r;
  endfunction

  function automatic int zsel_of(input int word, input int key_words);
    int z;
    z = 0;
    if (word == 24 && key_words == 4) z = 1;
    else if (word == 32 && key_words == 3) z = 2;
    else if (word == 32 && key_words == 4) z = 3;
    else if (word == 48 && key_words == 2) z = 2;
    else if (word == 48 && key_words == 3) z = 3;
    else if (word == 64 && key_words == 2) z = 2;
    else if (word == 64 && key_words == 3) z = 3;
    else if (word == 64 && key_words == 4) z = 4;
    return z;
  endfunction

  function automatic logic [61:0] zseq_of(input int sel);
    logic [61:0] z;
    case (sel)
      1:       z = Z1;
      2:       z = Z2;
      3:       z = Z3;
      4:       z = Z4;
      default: z = Z0;
    endcase
    return z;
  endfunction

endpackage

// File: rtl/simon_ks_word_update.sv
// Combinational Simon key-schedule step: produces k(i+m) from the current key window.
module simon_ks_word_update #(
  parameter int WORD      = 16,
  parameter int KEY_WORDS = 4
) (
  input  logic [WORD-1:0] k_oldest,
  input  logic [WORD-1:0] k_second,
  input  logic [WORD-1:0] k_newest,
  input  logic            z_bit,
  output logic [WORD-1:0] k_next
);

  logic [WORD-1:0] rot3;
  logic [WORD-1:0] tmp;
  logic [WORD-1:0] rot1;

  // Only the four-word schedule folds in k(i+1).
  always_comb begin
    rot3   = {k_newest[2:0], k_newest[WORD-1:3]};
    tmp    = (KEY_WORDS == 4) ? (rot3 ^ k_second) : rot3;
    rot1   = {tmp[0], tmp[WORD-1:1]};
    k_next = ~k_oldest ^ tmp ^ rot1 ^ WORD'(3) ^ WORD'(z_bit);
  end

endmodule

// File: rtl/simon_key_schedule_param.sv
// Bit-serial Simon key schedule: loads the key serially, then streams round-key bits on demand.
module simon_key_schedule_param
  import simon_pkg::*;
#(
  parameter int WORD      = 16,
  parameter int KEY_WORDS = 4
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             key_in,
  input  logic                                             load_valid,
  output logic                                             load_ready,
  input  logic                                             advance,
  input  logic                                             abort,
  output logic                                             key_bit,
  output logic                                             key_valid,
  output logic [$clog2(WORD)-1:0]                          bit_cnt,
  output logic [$clog2(rounds_of(WORD, KEY_WORDS))-1:0]    round_cnt,
  output logic                                             round_lsb,
  output logic                                             last_bit,
  output logic                                             done
);

  localparam int ROUNDS   = rounds_of(WORD, KEY_WORDS);
  localparam int ZSEL     = zsel_of(WORD, KEY_WORDS);
  localparam logic [61:0] ZSEQ = zseq_of(ZSEL);
  localparam int KEY_BITS = KEY_WORDS * WORD;
  localparam int BIT_W    = $clog2(WORD);
  localparam int RND_W    = $clog2(ROUNDS);
  localparam int LD_W     = $clog2(KEY_BITS + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD - 1);
  localparam logic [RND_W-1:0] RND_LAST = RND_W'(ROUNDS - 1);
  localparam logic [LD_W-1:0]  LD_LAST  = LD_W'(KEY_BITS - 1);

  if (ROUNDS == 0) begin : g_illegal_config
    $error("simon_key_schedule_param: unsupported WORD/KEY_WORDS pair");
  end

  ks_state_t state;
  ks_state_t state_nxt;

  // Word j of the live window sits at key_reg[j*WORD +: WORD]; word 0 is the current round key.
  logic [KEY_BITS-1:0] key_reg;
  logic [LD_W-1:0]     load_cnt;
  logic [5:0]          z_cnt;
  logic [WORD-1:0]     k_next;
  logic [WORD-1:0]     word0;
  logic                z_cur;
  logic                capture;
  logic                word_end;

  assign word0    = key_reg[WORD-1:0];
  assign z_cur    = ZSEQ[6'd61 - z_cnt];
  assign capture  = load_ready && load_valid && !abort;
  assign word_end = key_valid && advance && (bit_cnt == BIT_LAST);

  simon_ks_word_update #(
    .WORD      (WORD),
    .KEY_WORDS (KEY_WORDS)
  ) u_word_update (
    .k_oldest (key_reg[WORD-1:0]),
    .k_second (key_reg[2*WORD-1:WORD]),
    .k_newest (key_reg[KEY_BITS-1 -: WORD]),
    .z_bit    (z_cur),
    .k_next   (k_next)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (load_valid) state_nxt = ST_LOAD;
        ST_LOAD: if (load_valid && load_cnt == LD_LAST) state_nxt = ST_RUN;
        ST_RUN:  if (advance && bit_cnt == BIT_LAST && round_cnt == RND_LAST) state_nxt = ST_DONE;
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    load_ready = 1'b0;
    key_valid  = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE, ST_LOAD: load_ready = 1'b1;
      ST_RUN:           key_valid  = 1'b1;
      ST_DONE:          done       = 1'b1;
      default:          load_ready = 1'b0;
    endcase
  end

  // z index runs alongside round_cnt but wraps at 62 for the long schedules.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      bit_cnt   <= '0;
      round_cnt <= '0;
      load_cnt  <= '0;
      z_cnt     <= '0;
    end else begin
      if (capture) begin
        load_cnt <= (load_cnt == LD_LAST) ? '0 : load_cnt + 1'b1;
      end
      if (key_valid && advance) begin
        if (bit_cnt != BIT_LAST) begin
          bit_cnt <= bit_cnt + 1'b1;
        end else begin
          bit_cnt <= '0;
          if (round_cnt != RND_LAST) begin
            round_cnt <= round_cnt + 1'b1;
            z_cnt     <= (z_cnt == 6'd61) ? 6'd0 : z_cnt + 6'd1;
          end
        end
      end
      if (done) begin
        bit_cnt   <= '0;
        round_cnt <= '0;
        z_cnt     <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (capture) begin
        key_reg <= {key_in, key_reg[KEY_BITS-1:1]};
      end else if (!abort && word_end && round_cnt != RND_LAST) begin
        key_reg <= {k_next, key_reg[KEY_BITS-1:WORD]};
      end
    end
  end

  assign key_bit   = word0[bit_cnt];
  assign round_lsb = round_cnt[0];
  assign last_bit  = key_valid && (bit_cnt == BIT_LAST);

endmodule

// File: tb/tb_simon_key_schedule_param.sv
// Self-checking bench: directed Simon32/64 scenarios plus random keys on all ten configurations.
module tb_simon_key_schedule_param;

  localparam int NCFG = 10;
  localparam int CFG_W [NCFG] = '{16, 24, 24, 32, 32, 48, 48, 64, 64, 64};
  localparam int CFG_M [NCFG] = '{4, 3, 4, 3, 4, 2, 3, 2, 3, 4};
  localparam int CFG_R [NCFG] = '{32, 36, 36, 42, 44, 52, 54, 68, 69, 72};
  localparam int CFG_Z [NCFG] = '{0, 0, 1, 2, 3, 2, 3, 2, 3, 4};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Main directed instance (Simon32/64)
  logic       rst, key_in, load_valid, advance, abort;
  logic       load_ready, key_bit, key_valid, round_lsb, last_bit, done;
  logic [3:0] bit_cnt;
  logic [4:0] round_cnt;

  simon_key_schedule_param #(.WORD(16), .KEY_WORDS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .advance    (advance),
    .abort      (abort),
    .key_bit    (key_bit),
    .key_valid  (key_valid),
    .bit_cnt    (bit_cnt),
    .round_cnt  (round_cnt),
    .round_lsb  (round_lsb),
    .last_bit   (last_bit),
    .done       (done)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference model written straight from the published recurrence, using text z strings.
  function automatic bit zbit(input int s, input int i);
    string zs;
    case (s)
      0:       zs = "11111010001001010110000111001101111101000100101011000011100110";
      1:       zs = "10001110111110010011000010110101000111011111001001100001011010";
      2:       zs = "10101111011100000011010010011000101000010001111110010110110011";
      3:       zs = "11011011101011000110010111100000010010001010011100110100001111";
      default: zs = "11010001111001101011011000100000010111000011001010010011101111";
    endcase
    return zs.getc(i) == 8'h31;
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] x, input int r, input int n, input logic [63:0] mask);
    return ((x >> r) | (x << (n - r))) & mask;
  endfunction

  function automatic logic [63:0] ref_key(input int n, input int m, input int zs, input logic [255:0] kin, input int j);
    logic [63:0] k [80];
    logic [63:0] tmp;
    logic [63:0] mask;
    mask = (n == 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
    for (int i = 0; i < m; i++) k[i] = kin[i*64 +: 64] & mask;
    for (int i = 0; i + m <= j; i++) begin
      tmp = rotr(k[i+m-1], 3, n, mask);
      if (m == 4) tmp = tmp ^ k[i+1];
      k[i+m] = (~k[i] ^ tmp ^ rotr(tmp, 1, n, mask) ^ 64'(zbit(zs, i % 62)) ^ 64'd3) & mask;
    end
    return k[j];
  endfunction

  function automatic logic [255:0] widen16(input logic [63:0] kflat);
    logic [255:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) w[i*64 +: 64] = {48'd0, kflat[i*16 +: 16]};
    return w;
  endfunction

  logic [15:0] capWords [32];
  logic [15:0] refWords [32];
  int          holdErr;
  int          earlyDone;

  // Loads a 64-bit key (word 0 in the low bits) into the main DUT, optionally with idle gaps.
  task automatic applyStimulus(input logic [63:0] kflat, input bit gaps);
    int b;
    int early;
    b = 0;
    early = 0;
    while (b < 64) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        load_valid = 1'b0;
        key_in     = 1'($urandom_range(0, 1));
      end else begin
        load_valid = 1'b1;
        key_in     = kflat[b];
        b++;
      end
      @(negedge clk);
      if (key_valid && b < 64) early++;
    end
    load_valid = 1'b0;
    key_in     = 1'b0;
    checkOutput("load_early_run", 64'(early), 64'd0);
    checkOutput("load_run_entry", 64'(key_valid), 64'd1);
  endtask

  // Collects all 32 round-key words, optionally with random advance gaps and stray load_valid.
  task automatic runStream(input bit gaps);
    logic       kb;
    logic [3:0] bc;
    logic [4:0] rc;
    int         g;
    holdErr   = 0;
    earlyDone = 0;
    for (int r = 0; r < 32; r++) begin
      for (int b = 0; b < 16; b++) begin
        g = gaps ? $urandom_range(0, 5) : 0;
        if (g > 0) begin
          advance = 1'b0;
          kb = key_bit;
          bc = bit_cnt;
          rc = round_cnt;
          repeat (g) begin
            load_valid = 1'($urandom_range(0, 1));
            key_in     = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (key_bit !== kb || bit_cnt !== bc || round_cnt !== rc) holdErr++;
          end
          load_valid = 1'b0;
        end
        capWords[r][b] = key_bit;
        advance = 1'b1;
        @(negedge clk);
        if (done && !(r == 31 && b == 15)) earlyDone++;
      end
    end
    advance = 1'b0;
  endtask

  task automatic advanceTo(input int rt, input int bt, output bit found);
    found = 1'b0;
    advance = 1'b1;
    for (int t = 0; t < 1000; t++) begin
      if (key_valid && round_cnt == 5'(rt) && bit_cnt == 4'(bt)) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Ten configurations running in parallel with random keys and advance held high.
  logic [NCFG-1:0] finVec;

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int W = CFG_W[g];
    localparam int M = CFG_M[g];
    localparam int R = CFG_R[g];
    localparam int Z = CFG_Z[g];
    localparam logic [63:0] MASK = (W == 64) ? {64{1'b1}} : ((64'd1 << W) - 64'd1);

    logic                 c_rst, c_key, c_lv, c_adv, c_abort;
    logic                 c_ready, c_kb, c_kv, c_lsb, c_last, c_done;
    logic [$clog2(W)-1:0] c_bc;
    logic [$clog2(R)-1:0] c_rc;
    bit                   fin = 1'b0;

    assign finVec[g] = fin;

    simon_key_schedule_param #(.WORD(W), .KEY_WORDS(M)) u_cfg (
      .clk        (clk),
      .rst        (c_rst),
      .key_in     (c_key),
      .load_valid (c_lv),
      .load_ready (c_ready),
      .advance    (c_adv),
      .abort      (c_abort),
      .key_bit    (c_kb),
      .key_valid  (c_kv),
      .bit_cnt    (c_bc),
      .round_cnt  (c_rc),
      .round_lsb  (c_lsb),
      .last_bit   (c_last),
      .done       (c_done)
    );

    initial begin : run_cfg
      logic [255:0] kin;
      logic [63:0]  word;
      int           early;
      c_rst = 1'b1; c_key = 1'b0; c_lv = 1'b0; c_adv = 1'b0; c_abort = 1'b0;
      repeat (2) @(negedge clk);
      c_rst = 1'b0;
      kin = '0;
      for (int i = 0; i < M; i++) kin[i*64 +: 64] = {$urandom, $urandom} & MASK;
      for (int b2 = 0; b2 < M*W; b2++) begin
        c_key = kin[(b2 / W) * 64 + (b2 % W)];
        c_lv  = 1'b1;
        @(negedge clk);
      end
      c_lv = 1'b0;
      checkOutput($sformatf("cfg%0d_run_entry", g), 64'(c_kv), 64'd1);
      c_adv = 1'b1;
      early = 0;
      for (int r = 0; r < R; r++) begin
        word = '0;
        for (int bb = 0; bb < W; bb++) begin
          if (r == R-1 && bb == 0) checkOutput($sformatf("cfg%0d_last_round", g), 64'(c_rc), 64'(R-1));
          word[bb] = c_kb;
          @(negedge clk);
          if (c_done && !(r == R-1 && bb == W-1)) early++;
        end
        checkOutput($sformatf("cfg%0d_k%0d", g, r), word, ref_key(W, M, Z, kin, r));
      end
      c_adv = 1'b0;
      checkOutput($sformatf("cfg%0d_done", g), 64'(c_done), 64'd1);
      checkOutput($sformatf("cfg%0d_early_done", g), 64'(early), 64'd0);
      @(negedge clk);
      checkOutput($sformatf("cfg%0d_done_width", g), 64'(c_done), 64'd0);
      fin = 1'b1;
    end
  end

  initial begin : main_seq
    logic [63:0] kvec;
    logic [63:0] krnd;
    bit          found;
    rst = 1'b1; key_in = 1'b0; load_valid = 1'b0; advance = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_load_ready", 64'(load_ready), 64'd1);
    checkOutput("rst_key_valid", 64'(key_valid), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_last_bit", 64'(last_bit), 64'd0);
    checkOutput("rst_bit_cnt", 64'(bit_cnt), 64'd0);
    checkOutput("rst_round_cnt", 64'(round_cnt), 64'd0);
    rst = 1'b0;

    // advance while idle must not move anything
    advance = 1'b1;
    repeat (3) @(negedge clk);
    advance = 1'b0;
    checkOutput("idle_advance_ignored", 64'({key_valid, bit_cnt, round_cnt}), 64'd0);

    // Published Simon32/64 vector, loaded with toggling load_valid
    kvec = {16'h1918, 16'h1110, 16'h0908, 16'h0100};
    applyStimulus(kvec, 1'b1);
    runStream(1'b0);
    for (int r = 0; r < 4; r++)
      checkOutput($sformatf("tv_loaded_k%0d", r), 64'(capWords[r]), 64'(kvec[r*16 +: 16]));
    checkOutput("tv_k4", 64'(capWords[4]), 64'h71C3);
    for (int r = 0; r < 32; r++)
      checkOutput($sformatf("tv_model_k%0d", r), 64'(capWords[r]), ref_key(16, 4, 0, widen16(kvec), r));
    checkOutput("tv_early_done", 64'(earlyDone), 64'd0);
    checkOutput("tv_done_pulse", 64'(done), 64'd1);
    @(negedge clk);
    checkOutput("tv_done_width", 64'(done), 64'd0);
    checkOutput("tv_ready_after_done", 64'(load_ready), 64'd1);
    refWords = capWords;

    // Immediate reload, random advance gaps; stream must match the gap-free run
    applyStimulus(kvec, 1'b0);
    runStream(1'b1);
    checkOutput("gap_hold", 64'(holdErr), 64'd0);
    for (int r = 0; r < 32; r++)
      checkOutput($sformatf("gap_k%0d", r), 64'(capWords[r]), 64'(refWords[r]));
    checkOutput("gap_done_pulse", 64'(done), 64'd1);
    @(negedge clk);

    // Abort at round 5 bit 7, then reload
    krnd = {$urandom, $urandom};
    applyStimulus(krnd, 1'b0);
    advanceTo(5, 7, found);
    checkOutput("abort_reach", 64'(found), 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    advance = 1'b0;
    checkOutput("abort_key_valid", 64'(key_valid), 64'd0);
    checkOutput("abort_load_ready", 64'(load_ready), 64'd1);
    checkOutput("abort_counters", 64'({bit_cnt, round_cnt}), 64'd0);
    checkOutput("abort_no_done", 64'(done), 64'd0);
    applyStimulus(krnd, 1'b0);
    runStream(1'b0);
    checkOutput("reload_k0", 64'(capWords[0]), 64'(krnd[15:0]));
    checkOutput("reload_k5", 64'(capWords[5]), ref_key(16, 4, 0, widen16(krnd), 5));
    @(negedge clk);

    // Reset part-way through loading discards the partial key
    for (int i = 0; i < 20; i++) begin
      load_valid = 1'b1;
      key_in = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    load_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rstload_load_ready", 64'(load_ready), 64'd1);
    checkOutput("rstload_key_valid", 64'(key_valid), 64'd0);
    krnd = {$urandom, $urandom};
    applyStimulus(krnd, 1'b0);
    runStream(1'b0);
    checkOutput("rstload_k0", 64'(capWords[0]), 64'(krnd[15:0]));
    checkOutput("rstload_k3", 64'(capWords[3]), 64'(krnd[63:48]));
    @(negedge clk);

    // Abort together with advance on the very last bit: no done pulse
    applyStimulus(krnd, 1'b0);
    advanceTo(31, 15, found);
    checkOutput("final_reach", 64'(found), 64'd1);
    checkOutput("final_last_bit", 64'(last_bit), 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    advance = 1'b0;
    checkOutput("final_abort_done", 64'(done), 64'd0);
    checkOutput("final_abort_idle", 64'({load_ready, key_valid}), 64'b10);
    @(negedge clk);
    checkOutput("final_abort_done_later", 64'(done), 64'd0);

    // Wait (bounded) for the configuration sweep
    for (int t = 0; t < 20000 && finVec != {NCFG{1'b1}}; t++) @(negedge clk);
    checkOutput("cfg_sweep_finished", 64'(finVec), 64'({NCFG{1'b1}}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/simon_key_schedule_param.md
SIMON_KEY_SCHEDULE_PARAM -- requirements
Module: simon_key_schedule_param

Interface
REQ-001 Parameter WORD, default 16, Simon word size n; legal values 16, 24, 32, 48, 64.
REQ-002 Parameter KEY_WORDS, default 4, key words m; legal values 2, 3, 4.
REQ-003 Illegal (WORD, KEY_WORDS) pairs SHALL fail elaboration; legal pairs are 32/64, 48/72, 48/96, 64/96, 64/128, 96/96, 96/144, 128/128, 128/192, 128/256.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 key_in  in  1  serial key bit, word 0 first, LSB first within each word.
REQ-007 load_valid  in  1  key_in is valid this cycle.
REQ-008 load_ready  out  1  block accepts key bits (state IDLE or LOAD).
REQ-009 advance  in  1  datapath consumed the current key bit.
REQ-010 abort  in  1  abandon the current operation and return to IDLE.
REQ-011 key_bit  out  1  current round-key bit, bit bit_cnt of k_round_cnt.
REQ-012 key_valid  out  1  key_bit is valid (state RUN).
REQ-013 bit_cnt  out  clog2(WORD)  bit index within the current round.
REQ-014 round_cnt  out  clog2(ROUNDS)  current round index.
REQ-015 round_lsb  out  1  round_cnt[0], used for datapath parity.
REQ-016 last_bit  out  1  key_valid and bit_cnt==WORD-1.
REQ-017 done  out  1  one-cycle pulse after the final key bit is consumed.

Function
REQ-018 ROUNDS and the Z sequence index SHALL be derived from (WORD, KEY_WORDS):
- 16/4: 32, z0
- 24/3: 36, z0
- 24/4: 36, z1
- 32/3: 42, z2
- 32/4: 44, z3
- 48/2: 52, z2
- 48/3: 54, z3
- 64/2: 68, z2
- 64/3: 69, z3
- 64/4: 72, z4
REQ-019 FSM states: IDLE, LOAD, RUN, DONE.
REQ-020 IDLE->LOAD on load_valid; that bit SHALL be captured as key bit 0.
REQ-021 LOAD: each load_valid cycle captures one bit; a cycle without load_valid holds state.
REQ-022 LOAD->RUN the cycle after KEY_WORDS*WORD bits are captured; bit_cnt=0, round_cnt=0.
REQ-023 In RUN, key_bit SHALL equal bit bit_cnt of k_round_cnt, combinationally from registered state.
REQ-024 RUN with advance and bit_cnt<WORD-1: increment bit_cnt.
REQ-025 RUN with advance and bit_cnt==WORD-1: set bit_cnt=0 and increment round_cnt.
- At the same edge, shift the word window down and append k_(i+m).
REQ-026 Round-key recurrence:
- tmp = ror3(k_(i+m-1)); if m==4, tmp ^= k_(i+1)
- k_(i+m) = ~k_i ^ tmp ^ ror1(tmp) ^ z[i mod 62] ^ 3
REQ-027 z bit 0 is the first bit of the published sequence.
REQ-028 RUN->DONE on advance at bit_cnt==WORD-1 with round_cnt==ROUNDS-1; round_cnt SHALL NOT wrap.
REQ-029 DONE lasts exactly one cycle with done=1, then goes to IDLE.
REQ-030 advance outside RUN SHALL be ignored; load_valid outside IDLE/LOAD SHALL be ignored.
REQ-031 abort in any state SHALL force IDLE on the next edge and clear the counters; abort takes priority over advance and load_valid in the same cycle.
REQ-032 A new key may load immediately after DONE with no dead cycles beyond the DONE cycle.

Reset
REQ-033 rst SHALL force IDLE, bit_cnt=0, round_cnt=0, key_valid=0, done=0, last_bit=0, load_ready=1 on the next edge.
REQ-034 Key storage is not reset.
REQ-035 rst mid-LOAD or mid-RUN SHALL discard progress; rst overrides abort.

Structure
REQ-036 Package simon_pkg SHALL hold:
- the 62-bit Z0..Z4 constants
- functions rounds_of(WORD, KEY_WORDS) and zsel_of(WORD, KEY_WORDS)
- the FSM state enum
REQ-037 Key storage: KEY_WORDS x WORD registers; the loader shifts bits serially into word 0..m-1.
REQ-038 One sub-module, simon_ks_word_update, SHALL compute k_(i+m) combinationally.

Verification
REQ-039 WORD=16, KEY_WORDS=4, key words 0x0100, 0x0908, 0x1110, 0x1918:
- round keys 0..3 SHALL equal the loaded words
- k4 SHALL be 0x71C3
- done SHALL pulse after 32*16 advance cycles
REQ-040 All ten legal configurations, random keys, advance always high:
- every round-key word SHALL match the golden model
- ROUNDS and the done timing SHALL match
REQ-041 Random advance gaps of 0-5 cycles:
- key_bit and counters SHALL hold while advance=0
- the key stream SHALL be identical to the no-gap run
REQ-042 load_valid toggling during LOAD: only valid cycles captured; RUN entered after exactly KEY_WORDS*WORD valid bits.
REQ-043 abort at RUN round 5 bit 7 -> IDLE next cycle, then reload -> stream restarts at k0; rst in LOAD -> IDLE, load_ready=1.
REQ-044 Boundary: abort and advance asserted together at the final bit -> IDLE, no done pulse.
